// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit (XOR/AND/OR/XNOR) for the Y86-64 ALU path.
// Processes CHUNK bits per clock, LSB chunk first, and publishes result with zero/sign flags.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_r;
  logic [WIDTH-1:0] work_next;

  // Chunk select/insert is a constant-index mux so no variable part-selects are needed.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end

    unique case (op_q)
      2'b00: chunk_r = chunk_a ^ chunk_b;
      2'b01: chunk_r = chunk_a & chunk_b;
      2'b10: chunk_r = chunk_a | chunk_b;
      2'b11: chunk_r = ~(chunk_a ^ chunk_b);
      default: chunk_r = '0;
    endcase

    work_next = work_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        work_next[i*CHUNK +: CHUNK] = chunk_r;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;

    unique case (state_q)
      // DONE accepts a new start exactly like IDLE for back-to-back issue.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      StRun: begin
        work_d = work_next;
        idx_d  = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          idx_d    = '0;
          result_d = work_next;
          zf_d     = (work_next == '0);
          sf_d     = work_next[WIDTH-1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign zf     = zf_q;
  assign sf     = sf_q;

endmodule
